fifo_vc_gen: RTL
================

FIFO_VC_GEN -- requirements
Module: fifo_vc_gen

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 6, width in bits of each stored word.
REQ-002 SHALL have parameter ADDR_SIZE, default 2, log2 of queue depth; DEPTH = 2**ADDR_SIZE entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_L  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port push  input  1  write request.
REQ-006 SHALL have port pop  input  1  read request.
REQ-007 SHALL have port data_in  input  DATA_SIZE  word to write.
REQ-008 SHALL have port af_thr  input  ADDR_SIZE+1  almost-full threshold, in entries.
REQ-009 SHALL have port ae_thr  input  ADDR_SIZE+1  almost-empty threshold, in entries.
REQ-010 SHALL have port data_out  output  DATA_SIZE  registered read word.
REQ-011 SHALL have port data_valid  output  1  one-cycle strobe qualifying data_out.
REQ-012 SHALL have port data_count  output  ADDR_SIZE+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have ports fifo_empty, fifo_full, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port fifo_pause  output  1  registered back-pressure to upstream.
REQ-015 SHALL have port fifo_error  output  1  registered overflow/underflow indication.

Function
REQ-016 SHALL hold storage internally as DEPTH x DATA_SIZE registers, with read and write pointers ADDR_SIZE bits wide that wrap modulo DEPTH.
REQ-017 SHALL accept a write when push=1 and (fifo_full=0 or an accepted pop occurs in the same cycle): store data_in at wr_ptr, then increment wr_ptr.
REQ-018 SHALL accept a read when pop=1 and fifo_empty=0: on the next edge, data_out=mem[rd_ptr], data_valid=1, and rd_ptr increments. Latency is 1 cycle.
REQ-019 SHALL drive data_valid=0 and hold data_out in every cycle after no read was accepted.
REQ-020 SHALL update data_count as follows: +1 for write only, -1 for read only, unchanged for both or neither.
REQ-021 SHALL, when full with push and pop together, accept both; occupancy stays DEPTH and no error is raised.
REQ-022 SHALL, when empty with push and pop together, accept the write, reject the read (no bypass), set count to 1, and flag an error.
REQ-023 SHALL drop a push when full without pop: pointers and count are unchanged and an error is flagged.
REQ-024 SHALL ignore a pop when empty: pointers and count are unchanged, data_valid=0, and an error is flagged.
REQ-025 SHALL derive these flags combinationally from data_count: fifo_empty = (count==0); fifo_full = (count==DEPTH); almost_full = (count>=af_thr); almost_empty = (count<=ae_thr and count!=0).
REQ-026 SHALL register fifo_pause with hysteresis: set next edge when count>=af_thr; clear when count<=ae_thr; else hold. Set takes priority if both conditions hold.
REQ-027 SHALL assert fifo_error the edge after an overflow or underflow request (REQ-022..024); without the macro, it is a one-cycle pulse per offending cycle.

Reset
REQ-028 SHALL, while reset_L=0, asynchronously force: pointers=0, data_count=0, data_out=0, data_valid=0, fifo_pause=0, fifo_error=0. Flags then read empty=1, full=0, almost_full=(af_thr==0), almost_empty=0.
REQ-029 SHALL, on reset mid-operation, discard all queued entries; storage contents need not be cleared.

Configuration
REQ-030 SHALL support macro FIFO_VC_GEN_STICKY_ERR_EN. When defined, fifo_error stays 1 after the first offending cycle until reset_L=0. When undefined, behaviour follows REQ-027.

Verification
REQ-031 Bench SHALL cover these scenarios:
- Reset, then push 4 words 0x01..0x04 (DEPTH=4). Response: fifo_full=1, count=4. Then pop 4. Response: data_out 0x01..0x04, each 1 cycle after its pop with data_valid=1, then fifo_empty=1.
- Full with push and pop in the same cycle, data_in=0x2A. Response: count stays 4, fifo_error=0, and 0x2A is read out 4 pops later.
- Empty with pop=1 alone. Response: fifo_error=1 next cycle for exactly 1 cycle (macro off), data_valid=0. Same case with the macro defined: error stays 1 until reset.
- af_thr=3, ae_thr=1. Fill to 3: pause=1 the next cycle. Drain to 2: pause stays 1. Drain to 1: pause=0 the next cycle.
- Write 6 words and read 6 words, interleaved. Response: pointers wrap, FIFO order is preserved, count is never above 4.
- Assert reset_L=0 asynchronously with count=3. Response: count=0 and fifo_empty=1 immediately, with no clock edge needed.

Source files
------------

// File: rtl/fifo_vc_gen.sv
// Single-clock FIFO with occupancy flags, hysteretic pause and overflow/underflow error.
// Define FIFO_VC_GEN_STICKY_ERR_EN to make fifo_error sticky until reset.
module fifo_vc_gen #(
    parameter int unsigned DATA_SIZE = 6,
    parameter int unsigned ADDR_SIZE = 2
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic [ADDR_SIZE:0]   af_thr,
    input  logic [ADDR_SIZE:0]   ae_thr,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 data_valid,
    output logic [ADDR_SIZE:0]   data_count,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 fifo_pause,
    output logic                 fifo_error
);

    localparam int unsigned DEPTH = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] FullCnt = {1'b1, {ADDR_SIZE{1'b0}}};

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic                 rd_ok, wr_ok, err_cond, err_d, pause_d;

    assign data_count   = count_q;
    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == FullCnt);
    assign almost_full  = (count_q >= af_thr);
    assign almost_empty = (count_q <= ae_thr) && !fifo_empty;

    always_comb begin
        rd_ok    = pop && !fifo_empty;
        // A pop on a full FIFO frees the slot the simultaneous push needs.
        wr_ok    = push && (!fifo_full || rd_ok);
        err_cond = (pop && fifo_empty) || (push && fifo_full && !pop);

        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + (ADDR_SIZE + 1)'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - (ADDR_SIZE + 1)'(1);
        end

        pause_d = fifo_pause;
        if (count_q >= af_thr) begin
            pause_d = 1'b1;
        end else if (count_q <= ae_thr) begin
            pause_d = 1'b0;
        end

`ifdef FIFO_VC_GEN_STICKY_ERR_EN
        err_d = fifo_error || err_cond;
`else
        err_d = err_cond;
`endif
    end

    // Storage is deliberately left out of reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            fifo_pause <= 1'b0;
            fifo_error <= 1'b0;
        end else begin
            count_q    <= count_d;
            fifo_pause <= pause_d;
            fifo_error <= err_d;
            data_valid <= rd_ok;
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + ADDR_SIZE'(1);
            end
            if (rd_ok) begin
                data_out <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + ADDR_SIZE'(1);
            end
        end
    end

endmodule
